csb_slave_regfile: RTL and testbench



---
 rtl/csb_slave_pkg.sv | 13 +
 rtl/csb_slave_stall_gen.sv | 32 +++
 rtl/csb_slave_regfile.sv | 94 +++++++++
 tb/tb_csb_slave_regfile.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/csb_slave_pkg.sv
// csb_slave_pkg: shared types, constants and decode helper for the CSB register-file slave.
// Contents: rsp_kind_e (response type held in pipeline stage 1), CSB_SLV_ERR_DATA, in_range().
package csb_slave_pkg;

    typedef enum logic [1:0] {RSP_NONE, RSP_READ, RSP_WRC} rsp_kind_e;

    localparam logic [31:0] CSB_SLV_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic in_range(input logic [63:0] idx, input int unsigned num_regs);
        return idx < 64'(num_regs);
    endfunction

endpackage

// File: rtl/csb_slave_stall_gen.sv
// csb_slave_stall_gen: pseudo-random request back-pressure for the CSB slave (built only with CSB_SLAVE_STALL_EN).
// Ports: clk, rst_n (async active-low), prdy (registered ready, low for one cycle after an edge where lfsr[2:0]==0).
module csb_slave_stall_gen #(
    parameter logic [7:0] STALL_SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    output logic prdy
);

    logic [7:0] lfsr_q, lfsr_d;
    logic       prdy_q, prdy_d;

    // Fibonacci LFSR, taps 8,6,5,4
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        prdy_d = lfsr_q[2:0] != 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= STALL_SEED;
            prdy_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            prdy_q <= prdy_d;
        end
    end

    assign prdy = prdy_q;

endmodule

// File: rtl/csb_slave_regfile.sv
// csb_slave_regfile: CSB target with NUM_REGS registers (index 0 = read-only ID) and a fixed 2-cycle response pipeline.
// Ports: clk, rst_n (async active-low); request pvld/prdy/addr/write/wdata/nposted;
//        responses rvld/rdata (reads) and wr_complete (non-posted writes), strictly in order.
// Optional: define CSB_SLAVE_STALL_EN to add LFSR-driven prdy stalls.
module csb_slave_regfile
    import csb_slave_pkg::*;
#(
    parameter int                         CSB_ADDR_WIDTH = 16,
    parameter int                         CSB_DATA_WIDTH = 32,
    parameter int                         NUM_REGS       = 16,
    parameter logic [CSB_ADDR_WIDTH-1:0]  BASE_ADDR      = 16'h0000,
    parameter logic [CSB_DATA_WIDTH-1:0]  ID_VALUE       = 32'h0000_C5B0,
    parameter logic [7:0]                 STALL_SEED     = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pvld,
    output logic                      prdy,
    input  logic [CSB_ADDR_WIDTH-1:0] addr,
    input  logic                      write,
    input  logic [CSB_DATA_WIDTH-1:0] wdata,
    input  logic                      nposted,
    output logic                      wr_complete,
    output logic                      rvld,
    output logic [CSB_DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic                      accept, hit;
    logic [CSB_ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0]          widx;
    logic [CSB_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [CSB_DATA_WIDTH-1:0] regs_d [NUM_REGS];
    rsp_kind_e                 s1_kind_q, s1_kind_d;
    logic [CSB_DATA_WIDTH-1:0] s1_data_q, s1_data_d, rdata_q, rdata_d;
    logic                      rvld_q, rvld_d, wr_complete_q, wr_complete_d;

`ifdef CSB_SLAVE_STALL_EN
    csb_slave_stall_gen #(.STALL_SEED(STALL_SEED)) u_stall_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .prdy  (prdy)
    );
`else
    logic prdy_q, prdy_d, unused_seed;
    assign prdy_d      = 1'b1;
    assign unused_seed = ^STALL_SEED;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prdy_q <= 1'b0;
        else        prdy_q <= prdy_d;
    end
    assign prdy = prdy_q;
`endif

    always_comb begin
        // unsigned wrap: addresses below BASE_ADDR land far out of range
        idx    = addr - BASE_ADDR;
        hit    = in_range(64'(idx), NUM_REGS);
        widx   = idx[IDX_W-1:0];
        accept = pvld && prdy;
        regs_d = regs_q;
        if (accept && write && hit && idx != '0) regs_d[widx] = wdata;
        // posted writes leave nothing in the pipeline
        s1_kind_d     = !accept ? RSP_NONE : !write ? RSP_READ : nposted ? RSP_WRC : RSP_NONE;
        s1_data_d     = idx == '0 ? ID_VALUE : hit ? regs_q[widx] : CSB_DATA_WIDTH'(CSB_SLV_ERR_DATA);
        rvld_d        = s1_kind_q == RSP_READ;
        wr_complete_d = s1_kind_q == RSP_WRC;
        rdata_d       = rvld_d ? s1_data_q : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '{default: '0};
            s1_kind_q     <= RSP_NONE;
            s1_data_q     <= '0;
            rvld_q        <= 1'b0;
            wr_complete_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            regs_q        <= regs_d;
            s1_kind_q     <= s1_kind_d;
            s1_data_q     <= s1_data_d;
            rvld_q        <= rvld_d;
            wr_complete_q <= wr_complete_d;
            rdata_q       <= rdata_d;
        end
    end

    assign rvld        = rvld_q;
    assign wr_complete = wr_complete_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_csb_slave_regfile.sv
// tb_csb_slave_regfile: randomized + directed bench for csb_slave_regfile against a cycle-keyed response model.
module tb_csb_slave_regfile;

    localparam int          NR   = 16;
    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [31:0] ID   = 32'h0000_C5B0;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    logic        clk = 1'b0, rst_n = 1'b0, pvld = 1'b0, write = 1'b0, nposted = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        prdy, wr_complete, rvld;
    logic [31:0] rdata;

    csb_slave_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pvld        (pvld),
        .prdy        (prdy),
        .addr        (addr),
        .write       (write),
        .wdata       (wdata),
        .nposted     (nposted),
        .wr_complete (wr_complete),
        .rvld        (rvld),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    int          vectors = 0, miscompares = 0, cyc = 0, resp_cnt = 0;
    logic [31:0] mregs [NR];
    int          exp_kind [int];
    logic [31:0] exp_data [int];
    logic [31:0] last_rdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        exp_kind.delete();
        exp_data.delete();
        cyc = 0;
    endtask

    // accepted at edge cyc -> response visible after edge cyc+1
    task automatic model_accept();
        logic [15:0] mi;
        mi = addr - BASE;
        if (write) begin
            if (mi != 0 && mi < NR) mregs[mi[3:0]] = wdata;
            if (nposted) exp_kind[cyc + 1] = 2;
        end else begin
            exp_kind[cyc + 1] = 1;
            exp_data[cyc + 1] = mi == 0 ? ID : mi < NR ? mregs[mi[3:0]] : ERR;
        end
    endtask

    task automatic compare();
        int ek;
        if (!rst_n) begin
            last_rdata = '0;
            chk("rst_rvld", rvld, 0);
            chk("rst_wrc", wr_complete, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_prdy", prdy, 0);
        end else begin
            ek = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
            if (ek == 1) last_rdata = exp_data[cyc];
            chk("rvld", rvld, 32'(ek == 1));
            chk("wr_complete", wr_complete, 32'(ek == 2));
            chk("rdata", rdata, last_rdata);
`ifndef CSB_SLAVE_STALL_EN
            chk("prdy", prdy, 32'(cyc >= 1));
`endif
            if (rvld || wr_complete) resp_cnt++;
            exp_kind.delete(cyc);
        end
    endtask

    // one clock: model update at posedge, check at negedge, return just after negedge
    task automatic tick(input bit assert_rst = 1'b0);
        bit acc;
        acc = rst_n && pvld && prdy;
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (acc) model_accept();
        end
        if (assert_rst) begin
            #1 rst_n = 1'b0;
            model_clear();
        end
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic do_req(input bit w, input logic [15:0] a, input logic [31:0] d, input bit np);
        bit acc;
        int n;
        pvld = 1'b1; write = w; addr = a; wdata = d; nposted = np;
        n = 0;
        do begin
            acc = prdy;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no prdy expected accept within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pvld = 1'b0; write = 1'($urandom); addr = 16'($urandom); wdata = $urandom; nposted = 1'($urandom);
            tick();
        end
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < 5; i++) begin
            pvld = 1'($urandom); addr = 16'($urandom); wdata = $urandom; write = 1'($urandom);
            tick();
        end
        pvld = 1'b0;
        rst_n = 1'b1;
        chk("prdy_before_first_edge", prdy, 0);
        idle(3);

        do_req(1, BASE + 16'd3, 32'h1234_5678, 1);
        do_req(0, BASE + 16'd3, '0, 0);
        pvld = 1'b0;
        chk("np_write_wrc", wr_complete, 1);
        chk("np_write_no_rvld", rvld, 0);
        tick();
        chk("b2b_read_rvld", rvld, 1);
        chk("b2b_read_data", rdata, 32'h1234_5678);

        do_req(1, BASE + 16'd5, 32'hFFFF_0000, 0);
        pvld = 1'b0;
        tick();
        chk("posted_no_wrc", wr_complete, 0);
        do_req(0, BASE + 16'd5, '0, 0);
        pvld = 1'b0;
        tick();
        chk("posted_read_data", rdata, 32'hFFFF_0000);

        do_req(1, BASE, 32'h0, 1);
        do_req(0, BASE, '0, 0);
        pvld = 1'b0;
        tick();
        chk("id_read", rdata, 32'h0000_C5B0);
        do_req(0, BASE + 16'd16, '0, 0);
        pvld = 1'b0;
        tick();
        chk("err_read", rdata, 32'hDEAD_BEEF);
        idle(2);

        resp_cnt = 0;
        for (int i = 0; i < 20; i++)
            do_req(1'(i % 2), BASE + 16'($urandom_range(0, 17)), $urandom, 1);
        idle(4);
        chk("stream_resp_count", resp_cnt, 20);

        for (int i = 0; i < 400; i++) begin
            pvld    = ($urandom % 4) != 0;
            write   = 1'($urandom);
            nposted = 1'($urandom);
            wdata   = $urandom;
            addr    = ($urandom % 8 == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 19));
            tick();
        end
        idle(3);

        do_req(1, BASE + 16'd3, 32'hAAAA_5555, 1);
        pvld = 1'b1; write = 1'b0; addr = BASE + 16'd3;
        tick();
        addr = BASE + 16'd4;
        tick(1);
        pvld = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        idle(3);
        do_req(0, BASE + 16'd3, '0, 0);
        pvld = 1'b0;
        tick();
        chk("post_reset_rvld", rvld, 1);
        chk("post_reset_reg3", rdata, 32'h0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
